// File: rtl/uart.sv
// 8N1 UART with independent transmitter and receiver sharing one clock.
// The receiver double-registers the asynchronous rx line and samples each bit at its midpoint.
module uart #(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic       clk_50m,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       wr_en,
    output logic       tx,
    output logic       tx_busy,
    input  logic       rx,
    output logic       rdy,
    input  logic       rdy_clr,
    output logic [7:0] dout
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    // Transmitter
    state_e           tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             tx_q, tx_d;

    always_ff @(posedge clk_50m) begin
        if (reset) begin
            tx_state_q <= StIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
        end
    end

    // tx_d is the line level for the state being entered, so tx stays a clean flop output.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        unique case (tx_state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (wr_en) begin
                    tx_shift_d = din;
                    tx_cnt_d   = '0;
                    tx_state_d = StStart;
                    tx_d       = 1'b0;
                end
            end
            StStart: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = StData;
                    tx_d       = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            StData: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = StStop;
                        tx_d       = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_d       = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = StIdle;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = StIdle;
        endcase
    end

    assign tx      = tx_q;
    assign tx_busy = (tx_state_q != StIdle);

    // Receiver
    logic             rx_sync1_q, rx_sync2_q;
    state_e           rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [7:0]       dout_q, dout_d;
    logic             rdy_q, rdy_d;

    always_ff @(posedge clk_50m) begin
        if (reset) begin
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_state_q <= StIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            dout_q     <= '0;
            rdy_q      <= 1'b0;
        end else begin
            rx_sync1_q <= rx;
            rx_sync2_q <= rx_sync1_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            dout_q     <= dout_d;
            rdy_q      <= rdy_d;
        end
    end

    // The half-bit wait in StStart aligns every later full-bit wait to a bit midpoint.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        dout_d     = dout_q;
        rdy_d      = rdy_clr ? 1'b0 : rdy_q;
        unique case (rx_state_q)
            StIdle: begin
                rx_cnt_d = '0;
                if (!rx_sync2_q) rx_state_d = StStart;
            end
            StStart: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync2_q ? StIdle : StData;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            StData: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = StStop;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = StIdle;
                    // A completing byte overrides a same-cycle rdy_clr.
                    if (rx_sync2_q) begin
                        dout_d = rx_shift_q;
                        rdy_d  = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = StIdle;
        endcase
    end

    assign dout = dout_q;
    assign rdy  = rdy_q;

endmodule

// File: tb/tb_uart.sv
// Scoreboard bench for uart: stimulus pushes expected bytes, line monitors decode and compare.
module tb_uart;

    localparam int unsigned N    = 50000000 / 115200;
    localparam int unsigned HALF = N / 2;

    logic       clk_50m = 1'b0;
    logic       reset   = 1'b1;
    logic [7:0] din     = 8'h00;
    logic       wr_en   = 1'b0;
    logic       rdy_clr = 1'b0;
    logic       rx_drv  = 1'b1;
    logic       loopback = 1'b0;
    logic       tx, tx_busy, rdy, rx_line;
    logic [7:0] dout;

    assign rx_line = loopback ? tx : rx_drv;

    uart dut (
        .clk_50m (clk_50m),
        .reset   (reset),
        .din     (din),
        .wr_en   (wr_en),
        .tx      (tx),
        .tx_busy (tx_busy),
        .rx      (rx_line),
        .rdy     (rdy),
        .rdy_clr (rdy_clr),
        .dout    (dout)
    );

    always #10 clk_50m = ~clk_50m;

    int         checks = 0;
    int         passes = 0;
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    logic [7:0] last_good = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Decodes each transmitted frame by sampling the line at bit midpoints.
    initial begin : tx_mon
        logic [9:0] bits;
        int         c;
        bit         aborted;
        forever begin
            @(posedge clk_50m); #1;
            if (reset !== 1'b1 && tx === 1'b0) begin
                bits    = '1;
                c       = 0;
                aborted = 0;
                forever begin
                    if (reset === 1'b1) begin
                        aborted = 1;
                        break;
                    end
                    if (tx_busy !== 1'b1) break;
                    if (c % N == HALF && c / N < 10) bits[c/N] = tx;
                    c++;
                    if (c > 10 * N + 5) break;
                    @(posedge clk_50m); #1;
                end
                if (!aborted) begin
                    check("tx start bit", 32'(bits[0]), 32'd0);
                    check("tx stop bit", 32'(bits[9]), 32'd1);
                    check("tx busy length", c, 10 * N);
                    check("tx frame expected", 32'(tx_exp.size() > 0), 32'd1);
                    if (tx_exp.size() > 0) check("tx data", 32'(bits[8:1]), 32'(tx_exp.pop_front()));
                end
            end
        end
    end

    // On each rdy rise: compare dout, then clear rdy and confirm it drops with dout held.
    initial begin : rx_mon
        logic       prev;
        logic [7:0] e;
        prev = 1'b0;
        forever begin
            @(posedge clk_50m); #1;
            if (reset === 1'b1) begin
                prev = 1'b0;
            end else if (rdy === 1'b1 && !prev) begin
                check("rx byte expected", 32'(rx_exp.size() > 0), 32'd1);
                if (rx_exp.size() > 0) begin
                    e = rx_exp.pop_front();
                    check("rx dout", 32'(dout), 32'(e));
                    rdy_clr = 1'b1;
                    @(posedge clk_50m); #1;
                    rdy_clr = 1'b0;
                    check("rdy after clr", 32'(rdy), 32'd0);
                    check("dout after clr", 32'(dout), 32'(e));
                end
                prev = rdy;
            end else begin
                prev = rdy;
            end
        end
    end

    task automatic tx_send(input logic [7:0] b, input bit expect_it);
        @(negedge clk_50m);
        if (expect_it) tx_exp.push_back(b);
        din   = b;
        wr_en = 1'b1;
        @(negedge clk_50m);
        wr_en = 1'b0;
    endtask

    task automatic wait_tx_idle();
        int k = 0;
        do begin
            @(posedge clk_50m); #1;
            k++;
        end while (tx_busy === 1'b1 && k < 10 * N + 50);
        if (k >= 10 * N + 50) check("tx idle timeout", 32'(tx_busy), 32'd0);
        repeat (3) @(posedge clk_50m);
    endtask

    task automatic rx_send(input logic [7:0] b, input bit stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        if (stop) begin
            rx_exp.push_back(b);
            last_good = b;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_50m);
            rx_drv = bits[i];
            repeat (N - 1) @(negedge clk_50m);
        end
        @(negedge clk_50m);
        rx_drv = 1'b1;
        repeat (N) @(negedge clk_50m);
    endtask

    task automatic check_rx_quiet(input string name);
        @(posedge clk_50m); #1;
        check({name, " rdy"}, 32'(rdy), 32'd0);
        check({name, " dout"}, 32'(dout), 32'(last_good));
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] b1, b2;
        repeat (3) @(negedge clk_50m);
        reset = 1'b0;
        @(posedge clk_50m); #1;
        check("reset tx", 32'(tx), 32'd1);
        check("reset tx_busy", 32'(tx_busy), 32'd0);
        check("reset rdy", 32'(rdy), 32'd0);
        check("reset dout", 32'(dout), 32'd0);

        tx_send(8'hA5, 1'b1);
        wait_tx_idle();

        rx_send(8'h3C, 1'b1);

        // Second request mid-frame must be ignored.
        tx_send(8'h5A, 1'b1);
        repeat (1500) @(negedge clk_50m);
        din   = 8'h11;
        wr_en = 1'b1;
        @(negedge clk_50m);
        wr_en = 1'b0;
        wait_tx_idle();

        @(negedge clk_50m);
        rx_drv = 1'b0;
        repeat (100) @(negedge clk_50m);
        rx_drv = 1'b1;
        repeat (N) @(negedge clk_50m);
        check_rx_quiet("glitch");
        rx_send(8'h81, 1'b1);

        rx_send(8'hFF, 1'b0);
        check_rx_quiet("framing error");

        tx_send(8'h96, 1'b0);
        repeat (2000) @(negedge clk_50m);
        reset = 1'b1;
        @(posedge clk_50m); #1;
        check("midframe reset tx", 32'(tx), 32'd1);
        check("midframe reset tx_busy", 32'(tx_busy), 32'd0);
        check("midframe reset rdy", 32'(rdy), 32'd0);
        check("midframe reset dout", 32'(dout), 32'd0);
        @(negedge clk_50m);
        reset     = 1'b0;
        last_good = 8'h00;
        tx_send(8'h00, 1'b1);
        wait_tx_idle();

        // wr_en held high: first frame takes the first byte, the next frame the byte present then.
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        @(negedge clk_50m);
        tx_exp.push_back(b1);
        tx_exp.push_back(b2);
        din   = b1;
        wr_en = 1'b1;
        @(negedge clk_50m);
        din = b2;
        wait_tx_idle();
        @(negedge clk_50m);
        wr_en = 1'b0;
        wait_tx_idle();

        for (int i = 0; i < 4; i++) begin
            b1 = 8'($urandom);
            b2 = 8'($urandom_range(0, 255));
            fork
                begin
                    tx_send(b1, 1'b1);
                    wait_tx_idle();
                end
                rx_send(b2, 1'b1);
            join
        end

        @(negedge clk_50m);
        loopback = 1'b1;
        rx_exp.push_back(8'hC3);
        last_good = 8'hC3;
        tx_send(8'hC3, 1'b1);
        wait_tx_idle();
        repeat (N) @(negedge clk_50m);
        loopback = 1'b0;
        @(posedge clk_50m); #1;
        check("loopback dout", 32'(dout), 32'h0000_00C3);

        repeat (10) @(posedge clk_50m);
        check("tx scoreboard drained", tx_exp.size(), 0);
        check("rx scoreboard drained", rx_exp.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
